// File: rtl/cpu_pkg.sv
// Shared types for the cpu slice: boot loader FSM states and header size.
package cpu_pkg;

  localparam int LOADER_HDR_BYTES = 2;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    RUN,
    ERROR
  } loader_state_t;

endpackage

// File: rtl/boot_loader.sv
// Boot loader: receives a length-prefixed byte stream, writes it into program
// memory as halfwords from address 0, then hands memory to the cpu and
// releases cpu reset.
module boot_loader
  import cpu_pkg::*;
#(
  parameter  int MEM_DEPTH  = 2**12,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH*2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  output logic                  o_rx_ready,
  input  logic [0:1][7:0]       i_cpu_mem_di,
  input  logic [ADDR_WIDTH-1:0] i_cpu_mem_addr,
  input  logic                  i_cpu_mem_en,
  input  logic                  i_cpu_mem_rd_en,
  input  logic [0:1]            i_cpu_mem_wr_en,
  output logic [0:1][7:0]       o_cpu_mem_do,
  output logic [0:1][7:0]       o_mem_di,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_en,
  output logic                  o_mem_rd_en,
  output logic [0:1]            o_mem_wr_en,
  input  logic [0:1][7:0]       i_mem_do,
  output logic                  o_cpu_rst,
  output logic                  o_busy,
  output logic                  o_error
);

  loader_state_t         state, state_nxt;
  logic                  rx_ready;
  logic                  xfer;
  logic [7:0]            len_hi;
  logic [7:0]            lane0;
  logic [15:0]           hdr_len;
  logic                  len_zero;
  logic                  len_too_big;
  logic [15:0]           remaining;
  logic [ADDR_WIDTH-1:0] addr_cnt;

  // Loader-side memory port, registered so the write strobe is clean.
  logic                  ld_en;
  logic [0:1]            ld_wr_en;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [0:1][7:0]       ld_di;
  logic                  cpu_rst_q, busy_q, error_q;

  assign hdr_len     = {len_hi, i_rx_data};
  assign len_zero    = (hdr_len == 16'd0);
  assign len_too_big = (int'(hdr_len) > MEM_DEPTH);
  assign xfer        = i_rx_valid && rx_ready;

  assign o_rx_ready   = rx_ready;
  assign o_cpu_rst    = cpu_rst_q;
  assign o_busy       = busy_q;
  assign o_error      = error_q;
  assign o_cpu_mem_do = i_mem_do;

  // Next-state and byte-accept decode; ready depends only on registered state.
  always_comb begin
    state_nxt = state;
    rx_ready  = 1'b0;
    case (state)
      LEN_HI: begin
        rx_ready = 1'b1;
        if (i_rx_valid) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        rx_ready = 1'b1;
        if (i_rx_valid) begin
          if (len_zero)         state_nxt = RUN;
          else if (len_too_big) state_nxt = ERROR;
          else                  state_nxt = DATA_HI;
        end
      end
      DATA_HI: begin
        rx_ready = 1'b1;
        if (i_rx_valid) state_nxt = DATA_LO;
      end
      DATA_LO: begin
        rx_ready = 1'b1;
        if (i_rx_valid) state_nxt = WRITE;
      end
      WRITE:   state_nxt = (remaining == 16'd1) ? RUN : DATA_HI;
      RUN:     state_nxt = RUN;
      ERROR:   state_nxt = ERROR;
      default: state_nxt = LEN_HI;
    endcase
  end

  // State register, counters, byte latches and registered loader outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LEN_HI;
      addr_cnt  <= '0;
      remaining <= '0;
      len_hi    <= '0;
      lane0     <= '0;
      ld_en     <= 1'b0;
      ld_wr_en  <= 2'b00;
      ld_addr   <= '0;
      ld_di     <= '0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b1;
      error_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      // write strobe is a single-cycle pulse covering the WRITE state
      ld_en    <= 1'b0;
      ld_wr_en <= 2'b00;
      ld_addr  <= '0;
      ld_di    <= '0;
      case (state)
        LEN_HI: if (xfer) len_hi <= i_rx_data;
        LEN_LO: if (xfer) begin
          remaining <= hdr_len;
          if (len_zero) begin
            cpu_rst_q <= 1'b0;
            busy_q    <= 1'b0;
          end else if (len_too_big) begin
            error_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        DATA_HI: if (xfer) lane0 <= i_rx_data;
        DATA_LO: if (xfer) begin
          ld_en    <= 1'b1;
          ld_wr_en <= 2'b11;
          ld_addr  <= addr_cnt;
          ld_di    <= {lane0, i_rx_data};
        end
        WRITE: begin
          // counter may wrap after a full-depth load; it is unused afterwards
          addr_cnt  <= addr_cnt + ADDR_WIDTH'(2);
          remaining <= remaining - 16'd1;
          if (remaining == 16'd1) begin
            cpu_rst_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory port mux: cpu owns the port only once the load has completed.
  always_comb begin
    o_mem_en    = ld_en;
    o_mem_rd_en = 1'b0;
    o_mem_wr_en = ld_wr_en;
    o_mem_addr  = ld_addr;
    o_mem_di    = ld_di;
    if (state == RUN) begin
      o_mem_en    = i_cpu_mem_en;
      o_mem_rd_en = i_cpu_mem_rd_en;
      o_mem_wr_en = i_cpu_mem_wr_en;
      o_mem_addr  = i_cpu_mem_addr;
      o_mem_di    = i_cpu_mem_di;
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: expected memory writes are queued as
// bytes are sent and retired by a write monitor.
module tb_boot_loader;

  localparam int MEM_DEPTH  = 4096;
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH*2);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [15:0]           di;
  } wr_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [7:0]            rx_data = '0;
  logic                  rx_valid = 1'b0;
  logic                  rx_ready;
  logic [0:1][7:0]       cpu_di = '0;
  logic [ADDR_WIDTH-1:0] cpu_addr = '0;
  logic                  cpu_en = 1'b0;
  logic                  cpu_rd_en = 1'b0;
  logic [0:1]            cpu_wr_en = 2'b00;
  logic [0:1][7:0]       cpu_do;
  logic [0:1][7:0]       mem_di;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_en, mem_rd_en;
  logic [0:1]            mem_wr_en;
  logic [0:1][7:0]       mem_do = '0;
  logic                  cpu_rst, busy, error;

  int  checks = 0;
  int  failures = 0;
  wr_t exp_q[$];

  boot_loader #(.MEM_DEPTH(MEM_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid), .o_rx_ready(rx_ready),
    .i_cpu_mem_di(cpu_di), .i_cpu_mem_addr(cpu_addr), .i_cpu_mem_en(cpu_en),
    .i_cpu_mem_rd_en(cpu_rd_en), .i_cpu_mem_wr_en(cpu_wr_en),
    .o_cpu_mem_do(cpu_do),
    .o_mem_di(mem_di), .o_mem_addr(mem_addr), .o_mem_en(mem_en),
    .o_mem_rd_en(mem_rd_en), .o_mem_wr_en(mem_wr_en), .i_mem_do(mem_do),
    .o_cpu_rst(cpu_rst), .o_busy(busy), .o_error(error)
  );

  always #5 clk = ~clk;

  // Write monitor: every loader write must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && busy && (mem_wr_en != 2'b00 || mem_en)) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL spurious_write: got addr=%h di=%h wr_en=%b, required no write",
                 mem_addr, mem_di, mem_wr_en);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_di !== e.di || mem_wr_en !== 2'b11 ||
            mem_en !== 1'b1 || mem_rd_en !== 1'b0) begin
          failures++;
          $display("FAIL write: got addr=%h di=%h wr_en=%b en=%b rd=%b, required addr=%h di=%h wr_en=11 en=1 rd=0",
                   mem_addr, mem_di, mem_wr_en, mem_en, mem_rd_en, e.addr, e.di);
        end
      end
    end
  end

  task automatic do_reset();
    rx_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Presents a byte and returns #1 after the edge on which it was taken.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: byte %h not accepted within 50 cycles", b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int addr, input logic [7:0] l0, input logic [7:0] l1);
    wr_t e;
    e.addr = ADDR_WIDTH'(addr);
    e.di   = {l0, l1};
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({cpu_rst, busy, error, rx_ready} !== 4'b1101) begin
      failures++;
      $display("FAIL reset_flags: got rst/busy/err/ready=%b, required 1101",
               {cpu_rst, busy, error, rx_ready});
    end
    checks++;
    if (mem_en !== 1'b0 || mem_rd_en !== 1'b0 || mem_wr_en !== 2'b00 ||
        mem_di !== 16'h0 || mem_addr !== '0) begin
      failures++;
      $display("FAIL reset_mem: got en=%b rd=%b wr=%b di=%h addr=%h, required all zero",
               mem_en, mem_rd_en, mem_wr_en, mem_di, mem_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    push_exp(0, 8'hAB, 8'hCD);
    push_exp(2, 8'hEF, 8'h01);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'hAB); send_byte(8'hCD);
    send_byte(8'hEF); send_byte(8'h01);
    // now in the final WRITE cycle
    checks++;
    if (cpu_rst !== 1'b1 || mem_wr_en !== 2'b11) begin
      failures++;
      $display("FAIL basic_last_write: got cpu_rst=%b wr_en=%b, required 1 11", cpu_rst, mem_wr_en);
    end
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (cpu_rst !== 1'b0 || busy !== 1'b0 || rx_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_release: got cpu_rst=%b busy=%b ready=%b, required 0 0 0", cpu_rst, busy, rx_ready);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL basic_writes: %0d writes missing, required 0", exp_q.size());
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    send_byte(8'h00); send_byte(8'h00);
    rx_valid = 1'b0;
    checks++;
    if (cpu_rst !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin
      failures++;
      $display("FAIL zero_len: got cpu_rst=%b busy=%b err=%b, required 0 0 0", cpu_rst, busy, error);
    end
  endtask

  task automatic test_too_big();
    do_reset();
    send_byte(8'h10); send_byte(8'h01);
    checks++;
    if (error !== 1'b1 || rx_ready !== 1'b0 || cpu_rst !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL too_big: got err=%b ready=%b cpu_rst=%b busy=%b, required 1 0 1 0",
               error, rx_ready, cpu_rst, busy);
    end
    rx_data  = 8'h55;
    rx_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    checks++;
    if (error !== 1'b1 || rx_ready !== 1'b0 || cpu_rst !== 1'b1 || mem_en !== 1'b0) begin
      failures++;
      $display("FAIL too_big_hold: got err=%b ready=%b cpu_rst=%b en=%b, required 1 0 1 0",
               error, rx_ready, cpu_rst, mem_en);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] seq [4];
    seq = '{8'h00, 8'h01, 8'h12, 8'h34};
    do_reset();
    push_exp(0, 8'h12, 8'h34);
    for (int i = 0; i < 4; i++) begin
      send_byte(seq[i]);
      rx_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
    end
    checks++;
    if (exp_q.size() != 0 || cpu_rst !== 1'b0) begin
      failures++;
      $display("FAIL gaps: got pending=%0d cpu_rst=%b, required 0 0", exp_q.size(), cpu_rst);
    end
  endtask

  task automatic test_abort();
    do_reset();
    push_exp(0, 8'h11, 8'h22);
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    do_reset();
    checks++;
    if (exp_q.size() != 0 || cpu_rst !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_reset: got pending=%0d cpu_rst=%b busy=%b, required 0 1 1",
               exp_q.size(), cpu_rst, busy);
    end
    push_exp(0, 8'h56, 8'h78);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h56); send_byte(8'h78);
    rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || cpu_rst !== 1'b0) begin
      failures++;
      $display("FAIL abort_reload: got pending=%0d cpu_rst=%b, required 0 0", exp_q.size(), cpu_rst);
    end
  endtask

  task automatic test_run_mux();
    // follows test_abort, so the loader is already in RUN
    cpu_addr  = ADDR_WIDTH'(16'h10);
    cpu_en    = 1'b1;
    cpu_rd_en = 1'b1;
    cpu_wr_en = 2'b00;
    cpu_di    = 16'h1357;
    mem_do    = 16'h9ABC;
    rx_data   = 8'hEE;
    rx_valid  = 1'b1;
    #1;
    checks++;
    if (mem_addr !== ADDR_WIDTH'(16'h10) || mem_en !== 1'b1 || mem_rd_en !== 1'b1 ||
        mem_wr_en !== 2'b00 || mem_di !== 16'h1357) begin
      failures++;
      $display("FAIL run_mux: got addr=%h en=%b rd=%b wr=%b di=%h, required 010 1 1 00 1357",
               mem_addr, mem_en, mem_rd_en, mem_wr_en, mem_di);
    end
    checks++;
    if (cpu_do !== 16'h9ABC || rx_ready !== 1'b0) begin
      failures++;
      $display("FAIL run_do: got do=%h ready=%b, required 9abc 0", cpu_do, rx_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cpu_rst !== 1'b0 || busy !== 1'b0 || rx_ready !== 1'b0) begin
      failures++;
      $display("FAIL run_hold: got cpu_rst=%b busy=%b ready=%b, required 0 0 0", cpu_rst, busy, rx_ready);
    end
    rx_valid  = 1'b0;
    cpu_en    = 1'b0;
    cpu_rd_en = 1'b0;
    cpu_addr  = '0;
    cpu_di    = '0;
  endtask

  task automatic test_back_to_back_full();
    logic [15:0] k;
    do_reset();
    send_byte(8'h10); send_byte(8'h00);
    for (int i = 0; i < MEM_DEPTH; i++) begin
      k = 16'(i);
      push_exp(2 * i, k[7:0], k[15:8] ^ 8'h5A);
    end
    for (int i = 0; i < MEM_DEPTH; i++) begin
      k = 16'(i);
      send_byte(k[7:0]);
      send_byte(k[15:8] ^ 8'h5A);
    end
    checks++;
    if (mem_addr !== ADDR_WIDTH'(2 * MEM_DEPTH - 2) || cpu_rst !== 1'b1) begin
      failures++;
      $display("FAIL full_last_addr: got addr=%h cpu_rst=%b, required %h 1",
               mem_addr, cpu_rst, ADDR_WIDTH'(2 * MEM_DEPTH - 2));
    end
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || cpu_rst !== 1'b0 || error !== 1'b0) begin
      failures++;
      $display("FAIL full_done: got pending=%0d cpu_rst=%b err=%b, required 0 0 0",
               exp_q.size(), cpu_rst, error);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_too_big();
    test_gaps();
    test_abort();
    test_run_mux();
    test_back_to_back_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Sits between the external byte-stream receiver (UART RX), the cpu memory port and the shared program memory.
- During load, holds the cpu in reset and owns the memory port. It assembles received bytes into halfwords and writes them from address 0 upward.
- After the final write, it hands the memory port to the cpu and releases cpu reset.

Parameters:
- MEM_DEPTH, 2**12, number of halfwords in program memory (same meaning as cpu).
- ADDR_WIDTH, $clog2(MEM_DEPTH*2), localparam, byte address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_rx_data  in  8  received byte
- i_rx_valid  in  1  byte available
- o_rx_ready  out  1  loader accepts byte; transfer occurs when valid && ready
- i_cpu_mem_di  in  [0:1][7:0]  cpu write data
- i_cpu_mem_addr  in  ADDR_WIDTH  cpu byte address
- i_cpu_mem_en  in  1  cpu memory enable
- i_cpu_mem_rd_en  in  1  cpu read enable
- i_cpu_mem_wr_en  in  [0:1]  cpu byte-lane write enables
- o_cpu_mem_do  out  [0:1][7:0]  read data to cpu
- o_mem_di  out  [0:1][7:0]  write data to memory
- o_mem_addr  out  ADDR_WIDTH  memory byte address
- o_mem_en  out  1  memory enable
- o_mem_rd_en  out  1  memory read enable
- o_mem_wr_en  out  [0:1]  memory byte-lane write enables
- i_mem_do  in  [0:1][7:0]  memory read data
- o_cpu_rst  out  1  reset to cpu, active-high
- o_busy  out  1  load in progress
- o_error  out  1  length header exceeded MEM_DEPTH

Behaviour:
- Load protocol:
  - 2-byte header N: halfword count, first byte = N[15:8].
  - Then 2N data bytes. The first byte of each pair goes to lane 0, the second to lane 1.
  - Halfword k is written to byte address 2k.
- FSM states: LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, RUN, ERROR. All outputs below are registered unless noted.
- Reset: state=LEN_HI, addr counter=0, remaining=0, o_cpu_rst=1, o_busy=1, o_error=0. Loader memory outputs are zero: en=0, rd_en=0, wr_en=2'b00, di=0.
- LEN_HI: ready=1. On transfer, latch N[15:8] → LEN_LO.
- LEN_LO: ready=1. On transfer, latch N[7:0], then:
  - N==0 → RUN
  - N>MEM_DEPTH → ERROR
  - else → DATA_HI
- DATA_HI: ready=1. On transfer, latch lane-0 byte → DATA_LO.
- DATA_LO: ready=1. On transfer, latch lane-1 byte → WRITE.
- WRITE: ready=0. For exactly one cycle, drive en=1, rd_en=0, wr_en=2'b11, addr=counter, di={lane0,lane1}. Then addr += 2 and remaining -= 1. If remaining reaches 0 → RUN, else → DATA_HI.
- RUN:
  - ready=0; bytes are ignored.
  - o_cpu_rst=0 and o_busy=0, both registered, first valid in the cycle after the last WRITE cycle (or the cycle after LEN_LO when N==0).
  - Memory port outputs mirror the cpu inputs combinationally.
  - Stays in RUN until rst.
- ERROR: ready=0, o_error=1, o_cpu_rst=1, o_busy=0, memory en=0. Exit only via rst.
- o_cpu_mem_do = i_mem_do combinationally in all states. While not in RUN, cpu memory inputs are ignored.
- Valid gaps: any number of idle cycles between bytes is legal. The state holds while valid=0.
- rst mid-load: abort immediately, return to reset values. Partially written memory is not cleared.
- rst while in RUN: cpu reasserted into reset and a new load begins.
- N==MEM_DEPTH: the last write goes to byte address 2*MEM_DEPTH-2. The counter is then allowed to wrap, unused.

Decomposition:
- cpu_pkg holds loader_state_t (enum of the seven states) and LOADER_HDR_BYTES=2.
- No sub-module: the port mux is a small always_comb inside boot_loader. The FSM, counters and byte latches live in one always_ff.

Test Plan:
- Header 00 02, data AB CD EF 01, valid held high → one write addr=0 di={AB,CD} wr_en=11, later addr=2 di={EF,01}. o_cpu_rst falls the cycle after the second WRITE.
- Header 00 00 → RUN one cycle after LEN_LO transfer, no memory write, o_cpu_rst=0.
- Header 10 01 (4097, MEM_DEPTH=4096) → ERROR, o_error=1, o_rx_ready=0, o_cpu_rst=1 indefinitely.
- Header 00 01, data 12 34 with 5 idle cycles between every byte → single write addr=0 di={12,34}. No spurious writes during gaps.
- rst asserted after 3 of 4 data bytes of an N=2 load, then full load 00 01 56 78 → write addr=0 di={56,78}. The aborted second halfword is never written.
- In RUN, cpu drives addr=0x10 en=1 rd_en=1 wr_en=00, i_mem_do={9A,BC} → o_mem_* equal the cpu inputs the same cycle, o_cpu_mem_do={9A,BC}. A byte pushed on rx is not accepted.
